// File: rtl/bcd_value_setter_if.sv
// Bus interface for bcd_value_setter: button inputs, live value input and
// the display/commit outputs. The master side is the button/panel driver,
// the slave side is the setter itself.
interface bcd_value_setter_if;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [5:0] value_in;
  logic [5:0] value_out;
  logic       editing;
  logic [1:0] digit_sel;
  logic       commit;
  logic       blink;

  modport master (
    output btn_mode, btn_up, btn_down, value_in,
    input  value_out, editing, digit_sel, commit, blink
  );

  modport slave (
    input  btn_mode, btn_up, btn_down, value_in,
    output value_out, editing, digit_sel, commit, blink
  );
endinterface

// File: rtl/bcd_value_setter.sv
// bcd_value_setter: debounced MODE/UP/DOWN buttons edit a 0..MAX_VALUE value
// one decimal digit at a time (tens, then units) and emit a commit pulse.
// Optional blinking of the selected digit: define BCD_SETTER_BLINK_EN.
module bcd_value_setter #(
  parameter int MAX_VALUE       = 59,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_CYCLES    = 25000000
) (
  input  logic               clk,
  input  logic               rst,
  bcd_value_setter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    EDIT_TENS  = 2'd1,
    EDIT_UNITS = 2'd2,
    COMMIT     = 2'd3
  } state_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Value helpers: all arithmetic stays inside 6/7 bits
  function automatic logic [5:0] clamp_val(input logic [5:0] v);
    return (v > 6'(MAX_VALUE)) ? 6'(MAX_VALUE) : v;
  endfunction

  function automatic logic [5:0] join_tu(input logic [2:0] t, input logic [3:0] u);
    return 6'({3'b000, t} * 6'd10) + {2'b00, u};
  endfunction

  function automatic logic up_tens_ok(input logic [2:0] t, input logic [3:0] u);
    return ((({4'b0000, t} + 7'd1) * 7'd10) + {3'b000, u}) <= 7'(MAX_VALUE);
  endfunction

  function automatic logic up_units_ok(input logic [2:0] t, input logic [3:0] u);
    return (u < 4'd9) && (({1'b0, join_tu(t, u)} + 7'd1) <= 7'(MAX_VALUE));
  endfunction

  function automatic logic [2:0] max_tens(input logic [3:0] u);
    return 3'((7'(MAX_VALUE) - {3'b000, u}) / 7'd10);
  endfunction

  function automatic logic [3:0] max_units(input logic [2:0] t);
    logic [6:0] rem;
    rem = 7'(MAX_VALUE) - ({4'b0000, t} * 7'd10);
    return (rem > 7'd9) ? 4'd9 : rem[3:0];
  endfunction

  // Button path: bit 0 = MODE, bit 1 = UP, bit 2 = DOWN
  logic [2:0]    raw_s;
  logic [2:0]    sync1_r;
  logic [2:0]    sync2_r;
  logic [2:0]    acc_r;
  logic [2:0]    acc_d_r;
  logic [CW-1:0] cnt_r [3];
  logic [2:0]    press_s;

  // Working state and registered outputs
  state_t     state_r;
  logic [2:0] t_r;
  logic [3:0] u_r;
  logic [5:0] value_r;
  logic       editing_r;
  logic [1:0] digit_sel_r;
  logic       commit_r;
  logic       blink_r;

  logic       mode_ev_s;
  logic       up_ev_s;
  logic       down_ev_s;
  logic [2:0] t_nxt_s;
  logic [3:0] u_nxt_s;
  logic [5:0] clamp_in_s;
  logic [2:0] load_t_s;
  logic [3:0] load_u_s;

  assign raw_s      = {bus.btn_down, bus.btn_up, bus.btn_mode};
  assign press_s    = acc_r & ~acc_d_r;
  assign clamp_in_s = clamp_val(bus.value_in);
  assign load_t_s   = 3'(clamp_in_s / 6'd10);
  assign load_u_s   = 4'(clamp_in_s % 6'd10);

  // Synchronize, debounce and edge-detect the three buttons
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
      acc_r   <= 3'b000;
      acc_d_r <= 3'b000;
      for (int i = 0; i < 3; i++) cnt_r[i] <= '0;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      acc_d_r <= acc_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] == acc_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_LAST) begin
          acc_r[i] <= sync2_r[i];
          cnt_r[i] <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end
      end
    end
  end

  // Press arbitration and next working digits (MODE wins, UP+DOWN cancel)
  always_comb begin
    mode_ev_s = press_s[0];
    up_ev_s   = press_s[1] & ~press_s[2] & ~press_s[0];
    down_ev_s = press_s[2] & ~press_s[1] & ~press_s[0];
    t_nxt_s   = t_r;
    u_nxt_s   = u_r;
    case (state_r)
      EDIT_TENS: begin
        if (up_ev_s) begin
          if (up_tens_ok(t_r, u_r)) t_nxt_s = t_r + 3'd1;
          else                      t_nxt_s = 3'd0;
        end else if (down_ev_s) begin
          if (t_r != 3'd0) t_nxt_s = t_r - 3'd1;
          else             t_nxt_s = max_tens(u_r);
        end else begin
          t_nxt_s = t_r;
        end
      end
      EDIT_UNITS: begin
        if (up_ev_s) begin
          if (up_units_ok(t_r, u_r)) u_nxt_s = u_r + 4'd1;
          else                       u_nxt_s = 4'd0;
        end else if (down_ev_s) begin
          if (u_r != 4'd0) u_nxt_s = u_r - 4'd1;
          else             u_nxt_s = max_units(t_r);
        end else begin
          u_nxt_s = u_r;
        end
      end
      default: begin
        t_nxt_s = t_r;
        u_nxt_s = u_r;
      end
    endcase
  end

  // Edit FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      t_r         <= 3'd0;
      u_r         <= 4'd0;
      value_r     <= 6'd0;
      editing_r   <= 1'b0;
      digit_sel_r <= 2'b00;
      commit_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          value_r  <= clamp_in_s;
          commit_r <= 1'b0;
          if (mode_ev_s) begin
            t_r         <= load_t_s;
            u_r         <= load_u_s;
            state_r     <= EDIT_TENS;
            editing_r   <= 1'b1;
            digit_sel_r <= 2'b01;
          end else begin
            editing_r   <= 1'b0;
            digit_sel_r <= 2'b00;
          end
        end
        EDIT_TENS: begin
          t_r     <= t_nxt_s;
          u_r     <= u_nxt_s;
          value_r <= join_tu(t_nxt_s, u_nxt_s);
          if (mode_ev_s) begin
            state_r     <= EDIT_UNITS;
            digit_sel_r <= 2'b10;
          end else begin
            digit_sel_r <= 2'b01;
          end
        end
        EDIT_UNITS: begin
          t_r     <= t_nxt_s;
          u_r     <= u_nxt_s;
          value_r <= join_tu(t_nxt_s, u_nxt_s);
          if (mode_ev_s) begin
            state_r     <= COMMIT;
            editing_r   <= 1'b0;
            digit_sel_r <= 2'b00;
            commit_r    <= 1'b1;
          end else begin
            digit_sel_r <= 2'b10;
          end
        end
        COMMIT: begin
          state_r  <= IDLE;
          commit_r <= 1'b0;
          value_r  <= clamp_in_s;
        end
        default: begin
          state_r     <= IDLE;
          editing_r   <= 1'b0;
          digit_sel_r <= 2'b00;
          commit_r    <= 1'b0;
          value_r     <= 6'd0;
        end
      endcase
    end
  end

`ifdef BCD_SETTER_BLINK_EN
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  logic [BW-1:0] blink_cnt_r;
  logic          edit_next_s;
  logic          restart_s;

  // Will the FSM be editing next cycle, and does blink restart visible
  always_comb begin
    edit_next_s = 1'b0;
    restart_s   = 1'b0;
    case (state_r)
      IDLE: begin
        edit_next_s = mode_ev_s;
        restart_s   = mode_ev_s;
      end
      EDIT_TENS: begin
        edit_next_s = 1'b1;
        restart_s   = mode_ev_s | up_ev_s | down_ev_s;
      end
      EDIT_UNITS: begin
        edit_next_s = ~mode_ev_s;
        restart_s   = mode_ev_s | up_ev_s | down_ev_s;
      end
      default: begin
        edit_next_s = 1'b0;
        restart_s   = 1'b0;
      end
    endcase
  end

  // Blink half-period counter, restarted lit on every edit action
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_r <= '0;
      blink_r     <= 1'b0;
    end else if (!edit_next_s) begin
      blink_cnt_r <= '0;
      blink_r     <= 1'b0;
    end else if (restart_s) begin
      blink_cnt_r <= '0;
      blink_r     <= 1'b1;
    end else if (blink_cnt_r == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt_r <= '0;
      blink_r     <= ~blink_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BW'(1);
    end
  end
`else
  logic unused_blink_s;
  assign unused_blink_s = (BLINK_CYCLES > 0);

  // Blink disabled: output held low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) blink_r <= 1'b0;
    else     blink_r <= 1'b0;
  end
`endif

  assign bus.value_out = value_r;
  assign bus.editing   = editing_r;
  assign bus.digit_sel = digit_sel_r;
  assign bus.commit    = commit_r;
  assign bus.blink     = blink_r;

endmodule

// File: tb/tb_bcd_value_setter.sv
// Directed bench for bcd_value_setter (DEBOUNCE_CYCLES=4, MAX_VALUE=59).
// Expected display values are queued when a press is driven and popped when
// the DUT output is sampled on the falling edge.
module tb_bcd_value_setter;
  localparam int BTN_MODE = 0;
  localparam int BTN_UP   = 1;
  localparam int BTN_DOWN = 2;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   exp_q[$];

  bcd_value_setter_if bus();

  bcd_value_setter #(
    .MAX_VALUE(59),
    .DEBOUNCE_CYCLES(4),
    .BLINK_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_value(input string tag);
    int e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, int'(bus.value_out), e);
    end
  endtask

  task automatic set_btn(input int which, input logic lvl);
    case (which)
      BTN_MODE: bus.btn_mode = lvl;
      BTN_UP:   bus.btn_up   = lvl;
      BTN_DOWN: bus.btn_down = lvl;
      default:  bus.btn_mode = bus.btn_mode;
    endcase
  endtask

  // clean press: hold 12 cycles, release, settle 10 cycles, then compare
  task automatic press(input int which, input int expv, input string tag);
    exp_q.push_back(expv);
    @(negedge clk);
    set_btn(which, 1'b1);
    repeat (12) @(negedge clk);
    set_btn(which, 1'b0);
    repeat (10) @(negedge clk);
    check_value(tag);
  endtask

  // MODE press that should end in a commit pulse carrying expv
  task automatic press_commit(input int expv, input string tag);
    bit seen;
    seen = 1'b0;
    exp_q.push_back(expv);
    @(negedge clk);
    bus.btn_mode = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!seen && bus.commit === 1'b1) begin
        seen = 1'b1;
        check_value(tag);
        @(negedge clk);
        chk({tag, "_commit_width"}, int'(bus.commit), 0);
        chk({tag, "_editing_after"}, int'(bus.editing), 0);
      end
    end
    if (!seen) begin
      chk({tag, "_commit_timeout"}, 0, 1);
      void'(exp_q.pop_front());
    end
    bus.btn_mode = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int lat;
    bit hit;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    bus.value_in = 6'd37;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_value", int'(bus.value_out), 0);
    chk("rst_editing", int'(bus.editing), 0);
    chk("rst_digit_sel", int'(bus.digit_sel), 0);
    chk("rst_commit", int'(bus.commit), 0);
    chk("rst_blink", int'(bus.blink), 0);
    rst = 1'b0;
    exp_q.push_back(37);
    repeat (2) @(negedge clk);
    check_value("track_after_rst");
    chk("idle_editing", int'(bus.editing), 0);

    // edit 37 -> 47 -> 57 -> 56 and commit
    press(BTN_MODE, 37, "enter_tens");
    chk("enter_editing", int'(bus.editing), 1);
    chk("enter_digit_sel", int'(bus.digit_sel), 1);
`ifndef BCD_SETTER_BLINK_EN
    chk("blink_off", int'(bus.blink), 0);
`endif
    press(BTN_UP, 47, "tens_up_1");
    press(BTN_UP, 57, "tens_up_2");
    press(BTN_MODE, 57, "enter_units");
    chk("units_digit_sel", int'(bus.digit_sel), 2);
    press(BTN_DOWN, 56, "units_down");
    press_commit(56, "commit_56");
    exp_q.push_back(37);
    check_value("track_after_commit");

    // units wrap from working value 50
    bus.value_in = 6'd50;
    exp_q.push_back(50);
    repeat (2) @(negedge clk);
    check_value("track_50");
    press(BTN_MODE, 50, "enter_tens_50");
    press(BTN_MODE, 50, "enter_units_50");
    for (int i = 1; i <= 10; i++) begin
      press(BTN_UP, (i == 10) ? 50 : 50 + i, "units_up_wrap");
    end
    press_commit(50, "commit_50");

    // tens down-wrap from 09
    bus.value_in = 6'd9;
    repeat (3) @(negedge clk);
    press(BTN_MODE, 9, "enter_tens_09");
    press(BTN_DOWN, 59, "tens_down_wrap");
    press(BTN_DOWN, 49, "tens_down");

    // glitches on UP must not step the value
    exp_q.push_back(49);
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      bus.btn_up = 1'b1;
      repeat (3) @(negedge clk);
      bus.btn_up = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check_value("glitch_ignored");

    // clean 20-cycle press: one step, bounded latency, no repeat
    exp_q.push_back(59);
    @(negedge clk);
    bus.btn_up = 1'b1;
    lat = 0;
    hit = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (!hit && bus.value_out === 6'd59) begin
        hit = 1'b1;
        lat = k;
      end
    end
    chk("press_latency_hit", int'(hit), 1);
    chk("press_latency_le8", int'(lat >= 1 && lat <= 8), 1);
    repeat (12) @(negedge clk);
    bus.btn_up = 1'b0;
    repeat (10) @(negedge clk);
    check_value("held_no_repeat");

    // UP+DOWN together in EDIT_UNITS
    press(BTN_MODE, 59, "enter_units_59");
    exp_q.push_back(59);
    @(negedge clk);
    bus.btn_up   = 1'b1;
    bus.btn_down = 1'b1;
    repeat (12) @(negedge clk);
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    repeat (10) @(negedge clk);
    check_value("up_down_cancel");
    press_commit(59, "commit_59");

    // MODE+UP together in EDIT_TENS
    bus.value_in = 6'd42;
    exp_q.push_back(42);
    repeat (3) @(negedge clk);
    check_value("track_42");
    press(BTN_MODE, 42, "enter_tens_42");
    exp_q.push_back(42);
    @(negedge clk);
    bus.btn_mode = 1'b1;
    bus.btn_up   = 1'b1;
    repeat (12) @(negedge clk);
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    repeat (10) @(negedge clk);
    check_value("mode_wins");
    chk("mode_wins_digit_sel", int'(bus.digit_sel), 2);
    chk("mode_wins_editing", int'(bus.editing), 1);

    // reset mid-edit: immediate idle, no commit
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_value", int'(bus.value_out), 0);
    chk("midrst_editing", int'(bus.editing), 0);
    chk("midrst_digit_sel", int'(bus.digit_sel), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst_no_commit", int'(bus.commit), 0);
    end
    bus.value_in = 6'd23;
    rst = 1'b0;
    exp_q.push_back(23);
    repeat (2) @(negedge clk);
    check_value("track_after_midrst");
    chk("midrst_idle", int'(bus.editing), 0);
    chk("midrst_commit_after", int'(bus.commit), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
